// File: rtl/alu_pkg.sv
// Shared ALU package: sequencer state encoding, ALU control codes and the
// default datapath width. Used by the multiply sequencer, its bus interface
// and the ALU.
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response bundle of the multiply sequencer. The master side drives
// the start pulse and operands; the slave side (the sequencer) returns
// busy/done and the registered product.
interface alu_mul_sequencer_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              start_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;

  modport master (
    output start_i, src1_i, src2_i,
    input  busy_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, src1_i, src2_i,
    output busy_o, done_o, result_o, zero_o
  );
endinterface

// File: rtl/alu_mul_sequencer_alu.sv
// Single-cycle CPU ALU (AND/OR/ADD/SUB/SLT), purely combinational.
// Unknown control codes produce zero.
module alu_mul_sequencer_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [3:0]        ctrl_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  // Operation select on the control code
  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_CTRL_AND: result_o = src1_i & src2_i;
      ALU_CTRL_OR:  result_o = src1_i | src2_i;
      ALU_CTRL_ADD: result_o = src1_i + src2_i;
      ALU_CTRL_SUB: result_o = src1_i - src2_i;
      ALU_CTRL_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      default:      result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier sequencer driving the shared ALU (fixed to ADD).
// One partial product per clock; returns the low DATA_W bits of the product
// with a one-cycle done pulse.
// Optional build macro: ALU_MUL_EARLY_EXIT_EN -- finish as soon as the
// remaining multiplier bits are all zero instead of always running DATA_W
// iterations. Results are identical either way.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic                clk_i,
  input logic                rst_i,
  alu_mul_sequencer_if.slave bus
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e              r_state;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [DATA_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;
  logic                r_busy;
  logic                r_done;

  logic [DATA_W-1:0]   w_alu_sum;
  logic                w_alu_zero_unused;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic [DATA_W-1:0]   w_mplier_nxt;
  logic                w_last;

  // The ALU always adds the shifted multiplicand onto the accumulator;
  // whether that sum is kept depends on the current multiplier bit.
  alu_mul_sequencer_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .src1_i   (r_acc),
    .src2_i   (r_mcand),
    .ctrl_i   (ALU_CTRL_ADD),
    .result_o (w_alu_sum),
    .zero_o   (w_alu_zero_unused)
  );

  assign w_acc_nxt    = r_mplier[0] ? w_alu_sum : r_acc;
  assign w_mplier_nxt = r_mplier >> 1;

`ifdef ALU_MUL_EARLY_EXIT_EN
  // No set bits left to consume: the accumulator is already final.
  assign w_last = (r_cnt == CNT_LAST) || (w_mplier_nxt == '0);
`else
  assign w_last = (r_cnt == CNT_LAST);
`endif

  // Control FSM and datapath registers; all outputs registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // DONE accepts a new start directly so back-to-back ops lose no cycle
          if (bus.start_i) begin
            r_mcand  <= bus.src1_i;
            r_mplier <= bus.src2_i;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          // start_i is deliberately ignored here: no re-latch, no queuing
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_acc_nxt;
            r_zero   <= (w_acc_nxt == '0);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;
  assign bus.zero_o   = r_zero;

endmodule
